// File: rtl/bf16_pack_stage.sv
// Packs pairs of converted float elements into 2W-bit words and queues them for the writeback bus.
// Latency: the word-completing accept is visible at out_valid one cycle later when the FIFO is empty.
// Backpressure: in_ready drops while the word FIFO is full; words hold at the head until out_ready.
module bf16_pack_stage #(
    parameter int NEXP  = 8,
    parameter int NSIG  = 7,
    parameter int DEPTH = 4
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic                           in_valid,
    output logic                           in_ready,
    input  logic [NEXP+NSIG:0]             in_data,
    input  logic                           in_inexact,
    input  logic                           in_overflow,
    input  logic                           in_last,
    output logic                           out_valid,
    input  logic                           out_ready,
    output logic [2*(NEXP+NSIG+1)-1:0]     out_data,
    output logic [1:0]                     out_mask,
    input  logic                           clr_flags,
    output logic                           sticky_inexact,
    output logic                           sticky_overflow,
    output logic [15:0]                    elem_count
);

    localparam int W  = NEXP + NSIG + 1;
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = AW + 1;

    typedef enum logic {
        HALF_EMPTY = 1'b0,
        HALF_FULL  = 1'b1
    } state_t;

    state_t           state_q, state_d;
    logic [W-1:0]     hold_q, hold_d;
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]    count_q, count_d;
    logic             sticky_inexact_q, sticky_inexact_d;
    logic             sticky_overflow_q, sticky_overflow_d;
    logic [15:0]      elem_count_q, elem_count_d;

    // Word storage is not reset; the head is gated by out_valid so stale entries never show.
    logic [2*W-1:0]   data_mem_q [DEPTH];
    logic [1:0]       mask_mem_q [DEPTH];

    logic             accept;
    logic             pop;
    logic             push;
    logic [2*W-1:0]   push_data;
    logic [1:0]       push_mask;

    // Handshakes: ready comes from the registered count only, so a same-cycle pop cannot raise it.
    assign in_ready  = rst_n && (count_q < CW'(DEPTH));
    assign out_valid = (count_q != '0);
    assign accept    = in_valid && in_ready;
    assign pop       = out_valid && out_ready;

    assign out_data        = out_valid ? data_mem_q[rd_ptr_q] : '0;
    assign out_mask        = out_valid ? mask_mem_q[rd_ptr_q] : 2'b00;
    assign sticky_inexact  = sticky_inexact_q;
    assign sticky_overflow = sticky_overflow_q;
    assign elem_count      = elem_count_q;

    // Pairing FSM, FIFO pointer/count bookkeeping, sticky flags and element counter next-state.
    always_comb begin
        state_d           = state_q;
        hold_d            = hold_q;
        push              = 1'b0;
        push_data         = '0;
        push_mask         = 2'b00;
        wr_ptr_d          = wr_ptr_q;
        rd_ptr_d          = rd_ptr_q;
        count_d           = count_q;
        sticky_inexact_d  = clr_flags ? 1'b0 : sticky_inexact_q;
        sticky_overflow_d = clr_flags ? 1'b0 : sticky_overflow_q;
        elem_count_d      = elem_count_q;

        if (accept) begin
            elem_count_d = elem_count_q + 16'd1;
            // A flagged accept in the same cycle as a clear leaves the flag set.
            if (in_inexact) begin
                sticky_inexact_d = 1'b1;
            end
            if (in_overflow) begin
                sticky_overflow_d = 1'b1;
            end
            case (state_q)
                HALF_EMPTY: begin
                    if (in_last) begin
                        push      = 1'b1;
                        push_data = {{W{1'b0}}, in_data};
                        push_mask = 2'b01;
                    end else begin
                        hold_d  = in_data;
                        state_d = HALF_FULL;
                    end
                end
                HALF_FULL: begin
                    // The earlier element always lands in the lo half.
                    push      = 1'b1;
                    push_data = {in_data, hold_q};
                    push_mask = 2'b11;
                    state_d   = HALF_EMPTY;
                end
                default: begin
                    state_d = HALF_EMPTY;
                end
            endcase
        end

        if (push) begin
            wr_ptr_d = wr_ptr_q + AW'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + AW'(1);
        end
        case ({push, pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
    end

    // Control and status registers; reset discards any held element and all queued words.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q           <= HALF_EMPTY;
            hold_q            <= '0;
            wr_ptr_q          <= '0;
            rd_ptr_q          <= '0;
            count_q           <= '0;
            sticky_inexact_q  <= 1'b0;
            sticky_overflow_q <= 1'b0;
            elem_count_q      <= '0;
        end else begin
            state_q           <= state_d;
            hold_q            <= hold_d;
            wr_ptr_q          <= wr_ptr_d;
            rd_ptr_q          <= rd_ptr_d;
            count_q           <= count_d;
            sticky_inexact_q  <= sticky_inexact_d;
            sticky_overflow_q <= sticky_overflow_d;
            elem_count_q      <= elem_count_d;
        end
    end

    // Word storage write; a push can only happen when a slot is free.
    always_ff @(posedge clk) begin
        if (rst_n && push) begin
            data_mem_q[wr_ptr_q] <= push_data;
            mask_mem_q[wr_ptr_q] <= push_mask;
        end
    end

endmodule

// File: tb/tb_bf16_pack_stage.sv
// Self-checking bench for bf16_pack_stage: vector table, stall/reset sequences, long wrap run.
// Latency checked on word-completing accepts; scoreboard checks every popped word.
// Backpressure exercised by holding out_ready low until the FIFO fills.
module tb_bf16_pack_stage;

    localparam int W     = 16;
    localparam int DEPTH = 4;

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic            in_valid = 1'b0;
    logic            in_ready;
    logic [W-1:0]    in_data = '0;
    logic            in_inexact = 1'b0;
    logic            in_overflow = 1'b0;
    logic            in_last = 1'b0;
    logic            out_valid;
    logic            out_ready = 1'b0;
    logic [2*W-1:0]  out_data;
    logic [1:0]      out_mask;
    logic            clr_flags = 1'b0;
    logic            sticky_inexact;
    logic            sticky_overflow;
    logic [15:0]     elem_count;

    bf16_pack_stage #(.NEXP(8), .NSIG(7), .DEPTH(DEPTH)) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .in_valid        (in_valid),
        .in_ready        (in_ready),
        .in_data         (in_data),
        .in_inexact      (in_inexact),
        .in_overflow     (in_overflow),
        .in_last         (in_last),
        .out_valid       (out_valid),
        .out_ready       (out_ready),
        .out_data        (out_data),
        .out_mask        (out_mask),
        .clr_flags       (clr_flags),
        .sticky_inexact  (sticky_inexact),
        .sticky_overflow (sticky_overflow),
        .elem_count      (elem_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [15:0] dat;
        logic        last;
        logic        inx;
        logic        ovf;
        logic        clr;
        logic        push;
        logic [31:0] word;
        logic [1:0]  mask;
        logic        s_inx;
        logic        s_ovf;
    } vec_t;

    typedef struct {
        logic [31:0] d;
        logic [1:0]  m;
    } exp_t;

    vec_t        tbl [10];
    exp_t        sbq [$];
    int          checks = 0;
    int          errors = 0;
    logic        m_held = 1'b0;
    logic [15:0] m_hold = '0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic push_exp(input logic [31:0] d, input logic [1:0] m);
        exp_t e;
        e.d = d;
        e.m = m;
        sbq.push_back(e);
    endtask

    // Drive one element and return at posedge+1 after it has been accepted.
    task automatic send(input logic [15:0] d, input logic last, input logic inx,
                        input logic ovf, input logic clr);
        int t = 0;
        in_valid    = 1'b1;
        in_data     = d;
        in_last     = last;
        in_inexact  = inx;
        in_overflow = ovf;
        clr_flags   = clr;
        @(negedge clk);
        while (!in_ready && t < 500) begin
            @(negedge clk);
            t++;
        end
        checks++;
        if (!in_ready) begin
            errors++;
            $display("FAIL accept_timeout actual=in_ready_low expected=accept data=%h", d);
        end
        @(posedge clk);
        #1;
        in_valid    = 1'b0;
        in_last     = 1'b0;
        in_inexact  = 1'b0;
        in_overflow = 1'b0;
        clr_flags   = 1'b0;
    endtask

    // Reference pairing model feeding the scoreboard.
    task automatic model_send(input logic [15:0] d, input logic last);
        send(d, last, 1'b0, 1'b0, 1'b0);
        if (!m_held) begin
            if (last) begin
                push_exp({16'h0000, d}, 2'b01);
            end else begin
                m_held = 1'b1;
                m_hold = d;
            end
        end else begin
            push_exp({d, m_hold}, 2'b11);
            m_held = 1'b0;
        end
    endtask

    task automatic drain();
        int t = 0;
        while (sbq.size() != 0 && t < 2000) begin
            @(negedge clk);
            t++;
        end
        check("drain_queue_empty", sbq.size(), 0);
    endtask

    task automatic do_reset();
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        sbq.delete();
        m_held = 1'b0;
        rst_n  = 1'b1;
        @(posedge clk);
        #1;
    endtask

    // Output monitor: scoreboard compare on each pop, stability check while stalled.
    logic [31:0] st_d = '0;
    logic [1:0]  st_m = '0;
    logic        st_v = 1'b0;
    always @(negedge clk) begin
        if (!rst_n) begin
            st_v = 1'b0;
        end else begin
            if (st_v) begin
                check("stall_valid", out_valid, 1);
                check("stall_data", out_data, st_d);
                check("stall_mask", out_mask, st_m);
            end
            if (out_valid && out_ready) begin
                checks++;
                if (sbq.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_word actual=%h expected=none", out_data);
                end else begin
                    exp_t e;
                    e = sbq.pop_front();
                    checks--;
                    check("word_data", out_data, e.d);
                    check("word_mask", out_mask, e.m);
                end
            end
            st_v = out_valid && !out_ready;
            st_d = out_data;
            st_m = out_mask;
        end
    end

    initial begin
        //          dat       last  inx   ovf   clr   push  word           mask   s_inx s_ovf
        tbl[0] = '{16'h3F80, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h00000000, 2'b00, 1'b0, 1'b0};
        tbl[1] = '{16'h4000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 32'h40003F80, 2'b11, 1'b0, 1'b0};
        tbl[2] = '{16'hC1A0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 32'h0000C1A0, 2'b01, 1'b0, 1'b0};
        tbl[3] = '{16'h1234, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 32'h00000000, 2'b00, 1'b1, 1'b0};
        tbl[4] = '{16'h5678, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 32'h56781234, 2'b11, 1'b1, 1'b0};
        tbl[5] = '{16'h0001, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 32'h00000000, 2'b00, 1'b0, 1'b1};
        tbl[6] = '{16'h0002, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 32'h00020001, 2'b11, 1'b0, 1'b0};
        tbl[7] = '{16'h7F80, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 32'h00007F80, 2'b01, 1'b0, 1'b1};
        tbl[8] = '{16'h8000, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 32'h00000000, 2'b00, 1'b1, 1'b1};
        tbl[9] = '{16'hFFFF, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 32'hFFFF8000, 2'b11, 1'b1, 1'b1};

        // Reset values while rst_n is held low.
        repeat (3) @(posedge clk);
        #1;
        check("rst_in_ready", in_ready, 0);
        check("rst_out_valid", out_valid, 0);
        check("rst_out_data", out_data, 0);
        check("rst_out_mask", out_mask, 0);
        check("rst_sticky_inexact", sticky_inexact, 0);
        check("rst_sticky_overflow", sticky_overflow, 0);
        check("rst_elem_count", elem_count, 0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check("release_in_ready", in_ready, 1);

        // Vector table with consumer always ready.
        out_ready = 1'b1;
        for (int i = 0; i < 10; i++) begin
            send(tbl[i].dat, tbl[i].last, tbl[i].inx, tbl[i].ovf, tbl[i].clr);
            if (tbl[i].push) begin
                push_exp(tbl[i].word, tbl[i].mask);
                check("latency_out_valid", out_valid, 1);
                check("latency_out_data", out_data, tbl[i].word);
            end
            check("tbl_sticky_inexact", sticky_inexact, tbl[i].s_inx);
            check("tbl_sticky_overflow", sticky_overflow, tbl[i].s_ovf);
            check("tbl_elem_count", elem_count, i + 1);
        end
        drain();
        // A clear with no flagged accept drops both flags.
        clr_flags = 1'b1;
        @(posedge clk);
        #1;
        clr_flags = 1'b0;
        check("clr_sticky_inexact", sticky_inexact, 0);
        check("clr_sticky_overflow", sticky_overflow, 0);
        check("clr_keeps_count", elem_count, 10);

        // Stall: fill the FIFO, check ready drops, then drain with the 9th element held.
        out_ready = 1'b0;
        for (int i = 0; i < 2 * DEPTH; i++) begin
            model_send(16'h1000 + 16'(i), 1'b0);
        end
        check("full_in_ready", in_ready, 0);
        check("full_head_data", out_data, 32'h10011000);
        repeat (3) @(posedge clk);
        #1;
        out_ready = 1'b1;
        model_send(16'h1008, 1'b0);
        drain();
        repeat (3) @(posedge clk);
        #1;
        check("held_no_word", out_valid, 0);
        model_send(16'h1009, 1'b0);
        drain();

        // Reset with 3 words queued and an element held.
        out_ready = 1'b0;
        for (int i = 0; i < 7; i++) begin
            model_send(16'h2000 + 16'(i), 1'b0);
        end
        check("prereset_out_valid", out_valid, 1);
        rst_n = 1'b0;
        #1;
        check("reset_low_in_ready", in_ready, 0);
        @(posedge clk);
        #1;
        check("reset_out_valid", out_valid, 0);
        check("reset_in_ready", in_ready, 0);
        check("reset_out_data", out_data, 0);
        sbq.delete();
        m_held = 1'b0;
        rst_n  = 1'b1;
        @(posedge clk);
        #1;
        check("post_reset_in_ready", in_ready, 1);
        check("post_reset_elem_count", elem_count, 0);
        out_ready = 1'b1;
        send(16'h2222, 1'b0, 1'b0, 1'b0, 1'b0);
        send(16'h3333, 1'b0, 1'b0, 1'b0, 1'b0);
        push_exp(32'h33332222, 2'b11);
        check("post_reset_pair", out_data, 32'h33332222);
        drain();

        // Long run: counter wrap and many pointer wraps.
        do_reset();
        out_ready = 1'b1;
        for (int i = 0; i < 65537; i++) begin
            model_send(16'(i) ^ 16'hA5A5, (i == 65536) ? 1'b1 : 1'b0);
        end
        drain();
        check("wrap_elem_count", elem_count, 1);
        check("wrap_final_valid", out_valid, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/bf16_pack_stage.md
# bf16_pack_stage

Output stage that consumes the result stream of the integer-to-bfloat16 converter and packs pairs of 16-bit results into 32-bit words for the writeback bus. Each word carries a half-valid mask. The block buffers packed words in a small FIFO behind a valid/ready handshake. It keeps sticky inexact/overflow status and a running count of converted elements. It sits directly after the int-to-float conversion stage and ahead of the register-file/memory write port.

## Interface
- NEXP, 8, exponent width of the incoming float format
- NSIG, 7, stored significand width; element width W = NEXP+NSIG+1 (16 by default)
- DEPTH, 4, packed-word FIFO entries; power of two, at least 2
- clk  input  1  single clock, all state updates on rising edge
- rst_n  input  1  reset, synchronous, active-low
- in_valid  input  1  converter result valid
- in_ready  output  1  stage can accept a result this cycle
- in_data  input  W  converted float (sign, exponent, significand)
- in_inexact  input  1  converter inexact flag for in_data
- in_overflow  input  1  converter overflow flag for in_data
- in_last  input  1  final element of a burst; forces a partial word out
- out_valid  output  1  FIFO head valid
- out_ready  input  1  consumer accepts head
- out_data  output  2W  packed word {hi element, lo element}
- out_mask  output  2  bit0 = lo half valid, bit1 = hi half valid
- clr_flags  input  1  clear sticky flags
- sticky_inexact  output  1  OR of accepted in_inexact since last clear/reset
- sticky_overflow  output  1  OR of accepted in_overflow since last clear/reset
- elem_count  output  16  number of accepted elements, wraps modulo 2^16

## Operation
- The input handshake fires when in_valid and in_ready are both high. The output pop fires when out_valid and out_ready are both high.
- Pairing state: HALF_EMPTY or HALF_FULL, plus a W-bit hold register.
  - HALF_EMPTY, accept, in_last=0: store in_data in the hold register and go to HALF_FULL. Nothing is pushed.
  - HALF_EMPTY, accept, in_last=1: push {W'b0, in_data} with mask 01. Stay in HALF_EMPTY.
  - HALF_FULL, accept (any in_last): push {in_data, hold} with mask 11 and go to HALF_EMPTY. The earlier element is always in the lo half.
  - A held element with no further input stays held indefinitely. Only a second element or in_last flushes it.
- in_ready = rst_n && (fifo_count < DEPTH). It is computed from the registered count only; a same-cycle pop does not raise it.
- The FIFO is a circular buffer with read/write pointers of log2(DEPTH) bits plus a count. Pointers wrap from DEPTH-1 to 0.
  - Simultaneous push and pop leaves the count unchanged.
  - Push at full cannot occur, because in_ready is low.
- out_valid = (fifo_count != 0). out_data and out_mask are the head entry. They hold stable while out_valid && !out_ready.
- Sticky flags:
  - On each accept, sticky |= in_flag.
  - clr_flags clears both flags in the cycle after it is sampled.
  - If clr_flags and an accept carrying a set flag occur in the same cycle, the flag ends the cycle set (new event wins).
- elem_count increments by 1 per accept and wraps from 16'hFFFF to 0. clr_flags does not affect it.

## Timing
- Reset (rst_n low at a rising edge):
  - Pointers, count and hold register go to 0, and the state goes to HALF_EMPTY.
  - out_valid=0, out_data=0, out_mask=0, sticky_inexact=0, sticky_overflow=0, elem_count=0.
  - in_ready is 0 while rst_n is low and 1 in the first cycle after release.
  - Reset mid-burst discards any held element and all FIFO contents without emitting them.
- Latency: the accept that completes a word (second element, or in_last from HALF_EMPTY) makes that word visible at out_valid on the next cycle, provided the FIFO was empty.
- Throughput: one element accepted per cycle sustained, meaning one word every two cycles, when out_ready is held high.
- Sticky flags and elem_count are registered. They reflect an accept from the cycle after it.

## Test plan
- Reset, then accept 16'h3F80 then 16'h4000 with in_last=0 -> one cycle after the second accept: out_valid=1, out_data=32'h40003F80, out_mask=2'b11, elem_count=2.
- From HALF_EMPTY, accept 16'hC1A0 with in_last=1 -> out_data=32'h0000C1A0, out_mask=2'b01. The next pair still packs with its first element in the lo half.
- Hold out_ready=0 and stream 2*DEPTH+1 elements -> in_ready drops after DEPTH words, the 9th element (DEPTH=4) stays in the hold register, and words drain in order 0..3 with data stable while stalled.
- Accept an element with in_overflow=1 in the same cycle as clr_flags=1 -> sticky_overflow=1 afterwards. A later clr_flags with no flagged accept -> 0.
- Drive 65537 accepts -> elem_count reads 1. With DEPTH=4, pointer wrap is exercised more than 8000 times with no lost or duplicated words.
- Assert rst_n=0 with 3 words queued and an element held -> next cycle out_valid=0, in_ready=0. After release, in_ready=1 and the first new pair packs with no stale data.
